// File: rtl/mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// mul_seq_pkg
// Purpose : Shared definitions for the shift-add multiply sequencer.
//           Holds the sequencer state encoding, the number of shift-add steps
//           per product for the default operand width, and a small helper that
//           sizes the bit counter inside the datapath.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package mul_seq_pkg;

    // One shift-add step per operand bit; this is the default operand width,
    // so one full product takes MUL_CYCLES clock cycles.
    localparam int MUL_CYCLES = 32;

    // Sequencer states, in the order a command walks through them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        MUL   = 3'd3,
        WB    = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Width of a counter that must hold values 0 .. n-1 (at least one bit).
    function automatic int cnt_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_add_core.sv
// -----------------------------------------------------------------------------
// shift_add_core
// Purpose : Datapath for one shift-add multiplication. Holds the shifting
//           multiplicand (Rs), the shifting multiplier (Rm), the accumulator
//           and the step counter. A load clears the accumulator and counter;
//           each step conditionally adds Rs, then shifts Rs left and Rm right.
//           After WIDTH steps the accumulator holds (Rs*Rm) mod 2^WIDTH.
// Ports   : clk          - system clock
//           reset        - synchronous active-high reset
//           load_i       - load new operands (takes priority over step_i)
//           step_i       - perform one shift-add step
//           load_rs_i    - multiplicand to load
//           load_rm_i    - multiplier to load
//           acc_o        - current accumulator value
//           acc_next_o   - accumulator value after this cycle's edge
//           done_bit_o   - high on the step that completes the product
// -----------------------------------------------------------------------------
module shift_add_core
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = MUL_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] load_rs_i,
    input  logic [WIDTH-1:0] load_rm_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] acc_next_o,
    output logic             done_bit_o
);

    localparam int CB = cnt_bits(WIDTH);
    localparam logic [CB-1:0] LAST_STEP = CB'(WIDTH - 1);

    logic [WIDTH-1:0] rs_q, rs_d;
    logic [WIDTH-1:0] rm_q, rm_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CB-1:0]    bit_cnt_q, bit_cnt_d;

    // Next-state datapath: a load restarts the product from scratch, otherwise
    // a step adds the multiplicand when the multiplier LSB is set and shifts
    // both operands. With neither strobe everything simply holds.
    always_comb begin
        rs_d      = rs_q;
        rm_d      = rm_q;
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        if (load_i) begin
            rs_d      = load_rs_i;
            rm_d      = load_rm_i;
            acc_d     = '0;
            bit_cnt_d = '0;
        end else if (step_i) begin
            if (rm_q[0]) begin
                acc_d = acc_q + rs_q;
            end
            rs_d      = rs_q << 1;
            rm_d      = rm_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    // Datapath registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs_q      <= '0;
            rm_q      <= '0;
            acc_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            rs_q      <= rs_d;
            rm_q      <= rm_d;
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // The step counter never stops early, so every product takes exactly
    // WIDTH steps regardless of the operand values.
    assign done_bit_o = step_i && (bit_cnt_q == LAST_STEP);
    assign acc_o      = acc_q;
    assign acc_next_o = acc_d;

endmodule

// File: rtl/mul_seq_unit.sv
// -----------------------------------------------------------------------------
// mul_seq_unit
// Purpose : Self-timed multiply loop sitting next to a register file. On a
//           start command it reads Rs and Rm, multiplies them with a shift-add
//           datapath, writes the low WIDTH bits of the product to Rd, then
//           feeds the product back as the new Rm for iter_count iterations
//           (0 behaves as 1). Every iteration result is written back.
// Ports   : clk, reset            - clock, synchronous active-high reset
//           start                 - command strobe, only honoured in IDLE
//           rs_addr/rm_addr       - operand register addresses
//           rd_addr               - destination register for every result
//           iter_count            - number of iterations
//           in_address_1/2        - register file read addresses
//           read_enable_1/2       - register file read strobes
//           out_data_1/2          - register file read data (1-cycle latency)
//           write_address/data    - register file write port
//           write_enable          - one-cycle write strobe per iteration
//           busy                  - high whenever not IDLE
//           done                  - one-cycle pulse after the final write
// -----------------------------------------------------------------------------
module mul_seq_unit
    import mul_seq_pkg::*;
#(
    parameter int WIDTH  = MUL_CYCLES,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rm_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [CNT_W-1:0]  iter_count,
    output logic [ADDR_W-1:0] in_address_1,
    output logic [ADDR_W-1:0] in_address_2,
    output logic              read_enable_1,
    output logic              read_enable_2,
    input  logic [WIDTH-1:0]  out_data_1,
    input  logic [WIDTH-1:0]  out_data_2,
    output logic [ADDR_W-1:0] write_address,
    output logic [WIDTH-1:0]  write_data,
    output logic              write_enable,
    output logic              busy,
    output logic              done
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  rs_orig_q, rs_orig_d;

    logic              core_load;
    logic              core_step;
    logic [WIDTH-1:0]  core_load_rs;
    logic [WIDTH-1:0]  core_load_rm;
    logic [WIDTH-1:0]  core_acc;
    logic [WIDTH-1:0]  core_acc_next;
    logic              core_done_bit;

    logic [ADDR_W-1:0] in_address_1_q, in_address_1_d;
    logic [ADDR_W-1:0] in_address_2_q, in_address_2_d;
    logic              read_enable_q, read_enable_d;
    logic [ADDR_W-1:0] write_address_q, write_address_d;
    logic [WIDTH-1:0]  write_data_q, write_data_d;
    logic              write_enable_q, write_enable_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // The operand copy of Rs is kept here so every iteration multiplies by
    // the value read at the start, even if Rd aliases Rs. After LATCH the
    // datapath is reloaded from this copy with the previous product as Rm.
    assign core_load    = (state_q == LATCH) || (state_q == WB);
    assign core_step    = (state_q == MUL);
    assign core_load_rs = (state_q == LATCH) ? out_data_1 : rs_orig_q;
    assign core_load_rm = (state_q == LATCH) ? out_data_2 : core_acc;

    shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .load_i     (core_load),
        .step_i     (core_step),
        .load_rs_i  (core_load_rs),
        .load_rm_i  (core_load_rm),
        .acc_o      (core_acc),
        .acc_next_o (core_acc_next),
        .done_bit_o (core_done_bit)
    );

    // State and command registers. Reset returns everything to IDLE with the
    // latched command cleared, which also aborts any loop in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            count_q   <= '0;
            rs_orig_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            count_q   <= count_d;
            rs_orig_q <= rs_orig_d;
        end
    end

    // Next-state logic. A start is only looked at in IDLE, so pulses during
    // a run are dropped rather than queued. WB decides between another
    // iteration and finishing by checking whether this was the last count.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        count_d   = count_q;
        rs_orig_d = rs_orig_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = READ;
                    rd_addr_d = rd_addr;
                    count_d   = (iter_count == '0) ? CNT_W'(1) : iter_count;
                end
            end
            READ: begin
                state_d = LATCH;
            end
            LATCH: begin
                state_d   = MUL;
                rs_orig_d = out_data_1;
            end
            MUL: begin
                if (core_done_bit) begin
                    state_d = WB;
                end
            end
            WB: begin
                count_d = count_q - 1'b1;
                state_d = (count_q == CNT_W'(1)) ? DONE : MUL;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so that the registered outputs
    // line up with the state they belong to. The read addresses come from the
    // live inputs because READ is only ever entered from IDLE on the start
    // edge; the write data is the accumulator value the final step produces.
    always_comb begin
        busy_d          = (state_d != IDLE);
        done_d          = (state_d == DONE);
        read_enable_d   = (state_d == READ);
        in_address_1_d  = '0;
        in_address_2_d  = '0;
        write_enable_d  = (state_d == WB);
        write_address_d = '0;
        write_data_d    = '0;
        if (state_d == READ) begin
            in_address_1_d = rs_addr;
            in_address_2_d = rm_addr;
        end
        if (state_d == WB) begin
            write_address_d = rd_addr_q;
            write_data_d    = core_acc_next;
        end
    end

    // Output registers; reset forces every output low on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_address_1_q  <= '0;
            in_address_2_q  <= '0;
            read_enable_q   <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
            write_enable_q  <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            in_address_1_q  <= in_address_1_d;
            in_address_2_q  <= in_address_2_d;
            read_enable_q   <= read_enable_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            write_enable_q  <= write_enable_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign in_address_1  = in_address_1_q;
    assign in_address_2  = in_address_2_q;
    assign read_enable_1 = read_enable_q;
    assign read_enable_2 = read_enable_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign write_enable  = write_enable_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_unit
// Purpose : Directed bench for mul_seq_unit. Provides a small register file
//           with one-cycle read latency, logs every write, and walks through
//           a linear list of commands with hand-computed results.
// -----------------------------------------------------------------------------
module tb_mul_seq_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  rs_addr;
    logic [3:0]  rm_addr;
    logic [3:0]  rd_addr;
    logic [5:0]  iter_count;
    logic [3:0]  in_address_1;
    logic [3:0]  in_address_2;
    logic        read_enable_1;
    logic        read_enable_2;
    logic [31:0] out_data_1;
    logic [31:0] out_data_2;
    logic [3:0]  write_address;
    logic [31:0] write_data;
    logic        write_enable;
    logic        busy;
    logic        done;

    logic [31:0] regs [0:15];
    logic        poke;
    logic [3:0]  pokeAddr;
    logic [31:0] pokeData;

    logic [31:0] wrData [0:255];
    logic [3:0]  wrAddr [0:255];
    int          wrCount = 0;

    int total = 0;
    int bad   = 0;

    mul_seq_unit #(
        .WIDTH  (32),
        .ADDR_W (4),
        .CNT_W  (6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .rs_addr       (rs_addr),
        .rm_addr       (rm_addr),
        .rd_addr       (rd_addr),
        .iter_count    (iter_count),
        .in_address_1  (in_address_1),
        .in_address_2  (in_address_2),
        .read_enable_1 (read_enable_1),
        .read_enable_2 (read_enable_2),
        .out_data_1    (out_data_1),
        .out_data_2    (out_data_2),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .busy          (busy),
        .done          (done)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: reads return data one cycle after the enable,
    // writes land on the edge that samples write_enable, and the bench can
    // preload a register through the poke port.
    always @(posedge clk) begin
        if (read_enable_1) out_data_1 <= regs[in_address_1];
        if (read_enable_2) out_data_2 <= regs[in_address_2];
        if (write_enable === 1'b1) regs[write_address] <= write_data;
        if (poke) regs[pokeAddr] <= pokeData;
    end

    // Write monitor: records every write strobe in order.
    always @(posedge clk) begin
        if (write_enable === 1'b1) begin
            wrAddr[wrCount[7:0]] <= write_address;
            wrData[wrCount[7:0]] <= write_data;
            wrCount <= wrCount + 1;
        end
    end

    // Single comparison point; counts and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Preload one register of the model while the unit is idle.
    task automatic pokeReg(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        poke = 1'b1; pokeAddr = a; pokeData = d;
        @(negedge clk);
        poke = 1'b0;
    endtask

    // Present a command and raise start for the next rising edge.
    task automatic applyStimulus(input logic [3:0] rs, input logic [3:0] rm,
                                 input logic [3:0] rd, input logic [5:0] it);
        @(negedge clk);
        rs_addr = rs; rm_addr = rm; rd_addr = rd; iter_count = it;
        start = 1'b1;
    endtask

    // Issue a command and follow it to done. Cycle 1 is the cycle after the
    // start edge. Optionally re-pulses start with other operands at extraAt.
    task automatic runOp(input logic [3:0] rs, input logic [3:0] rm,
                         input logic [3:0] rd, input logic [5:0] it,
                         input int extraAt,
                         output int wrBase, output int doneCyc,
                         output int busyCyc, output logic busyAfter);
        int cyc;
        cyc = 0; busyCyc = 0; doneCyc = -1;
        wrBase = wrCount;
        applyStimulus(rs, rm, rd, it);
        while (doneCyc < 0 && cyc < 2500) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == extraAt);
            if (cyc == extraAt) begin
                rs_addr = 4'd1; rm_addr = 4'd1; rd_addr = 4'd5; iter_count = 6'd1;
            end
            if (busy) busyCyc++;
            if (done) doneCyc = cyc;
        end
        start = 1'b0;
        @(posedge clk); #1;
        busyAfter = busy;
    endtask

    initial begin
        int   base, dc, bc;
        logic ba;
        logic [31:0] expv;

        reset = 1'b1; start = 1'b0; poke = 1'b0; pokeAddr = '0; pokeData = '0;
        rs_addr = '0; rm_addr = '0; rd_addr = '0; iter_count = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_we", write_enable, 0);
        checkOutput("rst_re1", read_enable_1, 0);
        checkOutput("rst_re2", read_enable_2, 0);
        checkOutput("rst_wa", write_address, 0);
        checkOutput("rst_wd", write_data, 0);
        checkOutput("rst_ra1", in_address_1, 0);
        @(negedge clk);
        reset = 1'b0;

        pokeReg(4'd0, 32'd2);
        pokeReg(4'd1, 32'd1);

        // 2 * 1, single iteration
        $display("[TB] single iteration 2*1");
        runOp(4'd0, 4'd1, 4'd2, 6'd1, 0, base, dc, bc, ba);
        checkOutput("t1_done_cyc", dc, 36);
        checkOutput("t1_busy_cyc", bc, 36);
        checkOutput("t1_busy_after", ba, 0);
        checkOutput("t1_nwrites", wrCount - base, 1);
        checkOutput("t1_wdata", wrData[base], 32'h2);
        checkOutput("t1_waddr", wrAddr[base], 4'd2);
        checkOutput("t1_r2", regs[2], 32'h2);

        // 30 iterations: 2, 4, ..., 2^30
        $display("[TB] thirty iterations");
        runOp(4'd0, 4'd1, 4'd2, 6'd30, 0, base, dc, bc, ba);
        checkOutput("t2_done_cyc", dc, 3 + 30 * 33);
        checkOutput("t2_nwrites", wrCount - base, 30);
        for (int k = 0; k < 30; k++) begin
            expv = 32'h1 << (k + 1);
            checkOutput($sformatf("t2_w%0d", k + 1), wrData[base + k], expv);
        end
        checkOutput("t2_r2", regs[2], 32'h4000_0000);

        // 32 iterations: wraps to zero on the last one
        $display("[TB] thirty-two iterations with wrap");
        runOp(4'd0, 4'd1, 4'd2, 6'd32, 0, base, dc, bc, ba);
        checkOutput("t3_done_cyc", dc, 3 + 32 * 33);
        checkOutput("t3_nwrites", wrCount - base, 32);
        checkOutput("t3_w31", wrData[base + 30], 32'h8000_0000);
        checkOutput("t3_w32", wrData[base + 31], 32'h0);
        checkOutput("t3_r2", regs[2], 32'h0);

        // All-ones squared, count 0 behaves as 1
        $display("[TB] all-ones squared, count 0");
        pokeReg(4'd0, 32'hFFFF_FFFF);
        pokeReg(4'd1, 32'hFFFF_FFFF);
        runOp(4'd0, 4'd1, 4'd2, 6'd0, 0, base, dc, bc, ba);
        checkOutput("t4_done_cyc", dc, 36);
        checkOutput("t4_nwrites", wrCount - base, 1);
        checkOutput("t4_wdata", wrData[base], 32'h1);

        // Abort with reset in the third multiply of a 5-iteration run
        $display("[TB] reset abort during multiply");
        pokeReg(4'd0, 32'd2);
        pokeReg(4'd1, 32'd1);
        base = wrCount;
        applyStimulus(4'd0, 4'd1, 4'd2, 6'd5);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (79) @(posedge clk);
        #1;
        checkOutput("t5_busy_mid", busy, 1);
        checkOutput("t5_writes_before", wrCount - base, 2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_done", done, 0);
        checkOutput("t5_we", write_enable, 0);
        checkOutput("t5_re1", read_enable_1, 0);
        checkOutput("t5_wd", write_data, 0);
        checkOutput("t5_wa", write_address, 0);
        repeat (60) @(posedge clk);
        #1;
        checkOutput("t5_writes_after", wrCount - base, 2);
        checkOutput("t5_busy_later", busy, 0);
        runOp(4'd0, 4'd1, 4'd2, 6'd1, 0, base, dc, bc, ba);
        checkOutput("t5_rerun_done_cyc", dc, 36);
        checkOutput("t5_rerun_wdata", wrData[base], 32'h2);

        // Extra start while busy, Rd aliases Rs: 3, 9, 27 into R0
        $display("[TB] ignored start with aliased destination");
        pokeReg(4'd0, 32'd3);
        runOp(4'd0, 4'd1, 4'd0, 6'd3, 20, base, dc, bc, ba);
        checkOutput("t6_done_cyc", dc, 3 + 3 * 33);
        checkOutput("t6_w1", wrData[base], 32'd3);
        checkOutput("t6_w2", wrData[base + 1], 32'd9);
        checkOutput("t6_w3", wrData[base + 2], 32'd27);
        checkOutput("t6_waddr3", wrAddr[base + 2], 4'd0);
        repeat (60) @(posedge clk);
        #1;
        checkOutput("t6_nwrites", wrCount - base, 3);
        checkOutput("t6_busy_after", busy, 0);
        checkOutput("t6_r0", regs[0], 32'd27);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_seq_unit.md
Name: mul_seq_unit

Overview:
Multi-cycle shift-add multiply sequencer placed directly downstream of the reg_sync register file.
- Reads Rs and Rm through two register-file read ports and multiplies them.
- Feeds the product back as the new Rm for a programmable number of iterations.
- Writes every iteration's low WIDTH bits back through one register-file write port.
- Replaces the combinational multiplier plus bench-driven repeat loop with a self-timed hardware loop.

Parameters:
WIDTH, 32, operand/product width (product truncated to WIDTH)
ADDR_W, 4, register address width
CNT_W, 6, iteration-count width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  command strobe, accepted only in IDLE
rs_addr  in  ADDR_W  source register for multiplicand Rs
rm_addr  in  ADDR_W  source register for initial multiplier Rm
rd_addr  in  ADDR_W  destination register for every iteration result
iter_count  in  CNT_W  number of multiply iterations (0 treated as 1)
in_address_1  out  ADDR_W  to register file read port 1 (Rs)
in_address_2  out  ADDR_W  to register file read port 2 (Rm)
read_enable_1  out  1  read request port 1
read_enable_2  out  1  read request port 2
out_data_1  in  WIDTH  register file read data 1, valid one cycle after read_enable
out_data_2  in  WIDTH  register file read data 2, valid one cycle after read_enable
write_address  out  ADDR_W  register file write address
write_data  out  WIDTH  register file write data
write_enable  out  1  one-cycle write strobe
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the final write has been issued

Behaviour:
- Reset (sync, active-high): state=IDLE; all outputs 0; internal Rs/Rm/acc/count cleared. Reset asserted mid-operation aborts at the next edge; no write_enable is issued in that cycle or later.
- IDLE:
  - start=1 latches addresses and count (0 -> 1), then goes to READ.
  - start in any other state is ignored (no queueing).
- READ (1 cycle): in_address_1=rs_addr, in_address_2=rm_addr, read_enable_1/2=1. Next state LATCH.
- LATCH (1 cycle): capture out_data_1 -> Rs, out_data_2 -> Rm; acc=0; bit counter=0. Next state MUL.
- MUL (exactly WIDTH cycles):
  - Each cycle: if Rm[0], acc=acc+Rs (mod 2^WIDTH); Rs<<=1; Rm>>=1.
  - After WIDTH cycles, acc = (Rs*Rm) mod 2^WIDTH. No early termination, so latency is data-independent.
- WB (1 cycle):
  - write_address=rd_addr, write_data=acc, write_enable=1; count decremented.
  - If count now 0 -> DONE.
  - Otherwise reload Rs from the latched original Rs, Rm=acc, acc=0, -> MUL.
- DONE (1 cycle): done=1 -> IDLE. busy drops in the IDLE cycle.
- Outputs are registered. read/write enables and addresses are 0 outside their states.
- Latency from start to done = 3 + N*(WIDTH+1) cycles (N = effective count). For WIDTH=32, N=1: 36 cycles.
- Overflow wraps silently; no flag.
- rd_addr may equal rs_addr/rm_addr. Operands are internal copies, so writeback never corrupts the in-flight calculation.
- count is never 0 after latch; maximum count 2^CNT_W-1.

Decomposition:
- Shared package mul_seq_pkg: state enum (IDLE, READ, LATCH, MUL, WB, DONE) and the constant MUL_CYCLES=WIDTH.
- One natural sub-module: shift_add_core (Rs/Rm/acc datapath plus bit counter, with load/step/done_bit interface). The FSM and port driving stay in mul_seq_unit.

Test Plan:
- Preload R0=2, R1=1; start rs=0, rm=1, rd=2, iter=1 -> one write R2=0x00000002; done at cycle 36; busy high cycles 1-36.
- Same operands, iter=30 -> 30 writes to R2 with values 2,4,...,2^30; final R2=0x40000000; done at 3+30*33.
- R0=2, R1=1, iter=32 -> 31st write 0x80000000, 32nd write 0x00000000 (wrap).
- R0=0xFFFFFFFF, R1=0xFFFFFFFF, iter=0 -> treated as 1; write 0x00000001.
- Assert reset during MUL on iter=5 -> no further write_enable; all outputs 0 next cycle; a new start afterwards completes normally.
- start pulsed while busy, plus rd_addr=rs_addr=0 -> the extra start is ignored; result still uses the original R0 value on every iteration.
